// File: rtl/imm_seq_ctrl_pkg.sv
// Shared encodings for the immediate path: field modes and sequencer states.
// Also imported by the decoder so both sides agree on mode values.
package imm_seq_ctrl_pkg;

    typedef enum logic [1:0] {
        IMM_SEXT  = 2'b00,
        IMM_ZEXT  = 2'b01,
        IMM_UPPER = 2'b10,
        IMM_PAIR  = 2'b11
    } imm_mode_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_HOLD_HI = 2'b01,
        ST_OUT     = 2'b10
    } imm_state_e;

endpackage

// File: rtl/imm_seq_ctrl_if.sv
// Decode-side and ALU-side handshake bundle of the immediate sequencer.
// master = surrounding pipeline, slave = imm_seq_ctrl.
interface imm_seq_ctrl_if #(
    parameter int unsigned IN_W  = 8,
    parameter int unsigned OUT_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_imm;
    logic [1:0]       in_mode;
    logic             flush;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_imm;
    logic             pair_pending;

    modport master (
        output in_valid, in_imm, in_mode, flush, out_ready,
        input  in_ready, out_valid, out_imm, pair_pending
    );

    modport slave (
        input  in_valid, in_imm, in_mode, flush, out_ready,
        output in_ready, out_valid, out_imm, pair_pending
    );
endinterface

// File: rtl/imm_extend_core.sv
// Combinational operand builder: widens an immediate field according to its mode.
// OUT_W must be exactly 2*IN_W so every concatenation is full width.
module imm_extend_core
    import imm_seq_ctrl_pkg::*;
#(
    parameter int unsigned IN_W  = 8,
    parameter int unsigned OUT_W = 16
) (
    input  imm_mode_e        mode,
    input  logic [IN_W-1:0]  hi_byte,
    input  logic [IN_W-1:0]  field,
    output logic [OUT_W-1:0] value
);

    always_comb begin
        value = '0;
        unique case (mode)
            IMM_SEXT:  value = {{(OUT_W-IN_W){field[IN_W-1]}}, field};
            IMM_ZEXT:  value = {{(OUT_W-IN_W){1'b0}}, field};
            IMM_UPPER: value = {field, {(OUT_W-IN_W){1'b0}}};
            IMM_PAIR:  value = {hi_byte, field};
            default:   value = '0;
        endcase
    end

endmodule

// File: rtl/imm_seq_ctrl.sv
// Immediate-path sequencer: accepts 8-bit fields, builds 16-bit operands and
// holds each one on a registered valid/ready output until consumed.
module imm_seq_ctrl
    import imm_seq_ctrl_pkg::*;
#(
    parameter int unsigned IN_W  = 8,
    parameter int unsigned OUT_W = 16
) (
    input logic          clk,
    input logic          rst_n,
    imm_seq_ctrl_if.slave bus
);

    imm_state_e       state_q, state_d;
    logic [OUT_W-1:0] out_imm_q, out_imm_d;
    logic [IN_W-1:0]  hi_byte_q, hi_byte_d;

    logic             in_ready;
    logic             in_xfer;
    logic             out_xfer;
    logic             load_new;
    imm_mode_e        ext_mode;
    logic [OUT_W-1:0] ext_value;

    // In HOLD_HI the incoming beat is always the low byte, whatever its mode says.
    assign ext_mode = (state_q == ST_HOLD_HI) ? IMM_PAIR : imm_mode_e'(bus.in_mode);

    imm_extend_core #(
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_extend (
        .mode    (ext_mode),
        .hi_byte (hi_byte_q),
        .field   (bus.in_imm),
        .value   (ext_value)
    );

    always_comb begin
        in_ready = 1'b0;
        case (state_q)
            ST_IDLE, ST_HOLD_HI: in_ready = 1'b1;
            ST_OUT:              in_ready = bus.out_ready;
            default:             in_ready = 1'b0;
        endcase
        if (bus.flush) begin
            in_ready = 1'b0;
        end
    end

    assign in_xfer  = bus.in_valid & in_ready;
    assign out_xfer = (state_q == ST_OUT) & bus.out_ready;

    always_comb begin
        state_d   = state_q;
        out_imm_d = out_imm_q;
        hi_byte_d = hi_byte_q;
        load_new  = 1'b0;

        case (state_q)
            ST_IDLE: load_new = in_xfer;
            ST_HOLD_HI: begin
                if (in_xfer) begin
                    out_imm_d = ext_value;
                    state_d   = ST_OUT;
                end
            end
            ST_OUT: begin
                if (out_xfer) begin
                    load_new = in_xfer;
                    if (!in_xfer) begin
                        state_d = ST_IDLE;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase

        if (load_new) begin
            if (ext_mode == IMM_PAIR) begin
                hi_byte_d = bus.in_imm;
                state_d   = ST_HOLD_HI;
            end else begin
                out_imm_d = ext_value;
                state_d   = ST_OUT;
            end
        end

        // in_ready is already low under flush, so only the state needs overriding.
        if (bus.flush) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_IDLE;
            out_imm_q <= '0;
            hi_byte_q <= '0;
        end else begin
            state_q   <= state_d;
            out_imm_q <= out_imm_d;
            hi_byte_q <= hi_byte_d;
        end
    end

    assign bus.in_ready     = in_ready;
    assign bus.out_valid    = (state_q == ST_OUT);
    assign bus.out_imm      = out_imm_q;
    assign bus.pair_pending = (state_q == ST_HOLD_HI);

endmodule

// File: tb/tb_imm_seq_ctrl.sv
// Directed bench for imm_seq_ctrl: hand-computed vectors covering every mode,
// backpressure, streaming, flush and asynchronous reset.
module tb_imm_seq_ctrl;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_miss;

    imm_seq_ctrl_if #(.IN_W(8), .OUT_W(16)) bus ();

    imm_seq_ctrl #(
        .IN_W  (8),
        .OUT_W (16)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_miss++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [1:0] m, input logic [7:0] d);
        bus.in_valid = v;
        bus.in_mode  = m;
        bus.in_imm   = d;
    endtask

    initial begin
        n_vec  = 0;
        n_miss = 0;
        rst_n  = 1'b0;
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        drive(1'b0, 2'b00, 8'h00);
        #12;
        check("rst_out_valid", 16'(bus.out_valid), 16'h0);
        check("rst_out_imm", bus.out_imm, 16'h0000);
        check("rst_pair_pending", 16'(bus.pair_pending), 16'h0);
        check("rst_in_ready", 16'(bus.in_ready), 16'h1);
        #5 rst_n = 1'b1;
        step();
        check("idle_out_valid", 16'(bus.out_valid), 16'h0);

        // Single-beat modes, back to back.
        bus.out_ready = 1'b1;
        drive(1'b1, 2'b00, 8'hF3);
        step();
        check("sext_valid", 16'(bus.out_valid), 16'h1);
        check("sext_imm", bus.out_imm, 16'hFFF3);
        drive(1'b1, 2'b01, 8'hF3);
        step();
        check("zext_imm", bus.out_imm, 16'h00F3);
        drive(1'b1, 2'b10, 8'hF3);
        step();
        check("upper_imm", bus.out_imm, 16'hF300);
        check("upper_valid", 16'(bus.out_valid), 16'h1);
        drive(1'b0, 2'b00, 8'h00);
        step();
        check("drain_valid", 16'(bus.out_valid), 16'h0);

        // Pair composition; the low beat's SEXT mode must be ignored.
        drive(1'b1, 2'b11, 8'h12);
        step();
        check("pair_pending_hi", 16'(bus.pair_pending), 16'h1);
        check("pair_no_valid", 16'(bus.out_valid), 16'h0);
        drive(1'b1, 2'b00, 8'h34);
        step();
        check("pair_pending_lo", 16'(bus.pair_pending), 16'h0);
        check("pair_valid", 16'(bus.out_valid), 16'h1);
        check("pair_imm", bus.out_imm, 16'h1234);
        drive(1'b0, 2'b00, 8'h00);
        step();

        // Backpressure.
        bus.out_ready = 1'b0;
        drive(1'b1, 2'b00, 8'h05);
        step();
        check("bp_first_imm", bus.out_imm, 16'h0005);
        drive(1'b1, 2'b00, 8'h06);
        #1;
        check("bp_in_ready_low", 16'(bus.in_ready), 16'h0);
        step();
        check("bp_hold_imm", bus.out_imm, 16'h0005);
        check("bp_hold_valid", 16'(bus.out_valid), 16'h1);
        bus.out_ready = 1'b1;
        #1;
        check("bp_in_ready_high", 16'(bus.in_ready), 16'h1);
        step();
        check("bp_accept_imm", bus.out_imm, 16'h0006);
        drive(1'b0, 2'b00, 8'h00);
        step();
        check("bp_only_one", 16'(bus.out_valid), 16'h0);

        // Streaming SEXT with no bubbles.
        drive(1'b1, 2'b00, 8'h7F);
        step();
        check("stream0", bus.out_imm, 16'h007F);
        drive(1'b1, 2'b00, 8'h80);
        step();
        check("stream1", bus.out_imm, 16'hFF80);
        check("stream1_valid", 16'(bus.out_valid), 16'h1);
        drive(1'b1, 2'b00, 8'h00);
        step();
        check("stream2", bus.out_imm, 16'h0000);
        drive(1'b1, 2'b00, 8'hFF);
        step();
        check("stream3", bus.out_imm, 16'hFFFF);
        check("stream3_valid", 16'(bus.out_valid), 16'h1);
        drive(1'b0, 2'b00, 8'h00);
        step();

        // Flush while a high byte is held, with a live input in the same cycle.
        drive(1'b1, 2'b11, 8'hAB);
        step();
        check("flush_pending_before", 16'(bus.pair_pending), 16'h1);
        drive(1'b1, 2'b00, 8'hCD);
        bus.flush = 1'b1;
        #1;
        check("flush_in_ready", 16'(bus.in_ready), 16'h0);
        step();
        bus.flush = 1'b0;
        drive(1'b0, 2'b00, 8'h00);
        check("flush_pending_after", 16'(bus.pair_pending), 16'h0);
        check("flush_no_valid", 16'(bus.out_valid), 16'h0);
        check("flush_imm_kept", bus.out_imm, 16'hFFFF);
        step();
        check("flush_still_idle", 16'(bus.out_valid), 16'h0);
        drive(1'b1, 2'b01, 8'h01);
        step();
        check("post_flush_imm", bus.out_imm, 16'h0001);
        check("post_flush_valid", 16'(bus.out_valid), 16'h1);

        // Asynchronous reset between edges while in OUT.
        drive(1'b0, 2'b00, 8'h00);
        bus.out_ready = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("arst_out_valid", 16'(bus.out_valid), 16'h0);
        check("arst_out_imm", bus.out_imm, 16'h0000);
        #2 rst_n = 1'b1;
        #1;
        check("arst_in_ready", 16'(bus.in_ready), 16'h1);
        step();
        check("arst_idle_valid", 16'(bus.out_valid), 16'h0);
        check("arst_idle_pending", 16'(bus.pair_pending), 16'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/imm_seq_ctrl.md
Name: imm_seq_ctrl

Overview:
- Sequencing controller for the immediate path of the 16-bit datapath.
- Accepts 8-bit immediate fields from decode over a valid/ready handshake.
- Builds the 16-bit operand using one of four modes: sign-extend, zero-extend, upper-load, or two-beat pair composition.
- Presents the result to the ALU-B mux through a registered valid/ready output, holding it until it is consumed.

Parameters:
- IN_W, 8, immediate field width.
- OUT_W, 16, operand width; must equal 2*IN_W.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  decode presents a field.
- in_ready  output  1  controller accepts the field this cycle.
- in_imm  input  IN_W  immediate field.
- in_mode  input  2  00 SEXT, 01 ZEXT, 10 UPPER, 11 PAIR.
- flush  input  1  synchronous abort from a branch/jump redirect.
- out_valid  output  1  out_imm is valid.
- out_ready  input  1  consumer accepts out_imm.
- out_imm  output  OUT_W  built operand.
- pair_pending  output  1  high byte of a PAIR is held, waiting for the low beat.

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-low (rst_n).
- Reset values:
  - state=IDLE, out_valid=0, out_imm=0, pair_pending=0, internal hi_byte=0.
  - in_ready is combinational; it is 1 in IDLE after reset.
- Transfer rules:
  - Input transfer occurs when in_valid&in_ready.
  - Output transfer occurs when out_valid&out_ready.
- State IDLE:
  - in_ready=1.
  - On transfer with SEXT: out_imm={{8{in_imm[7]}},in_imm}; go to OUT.
  - On transfer with ZEXT: out_imm={8'h00,in_imm}; go to OUT.
  - On transfer with UPPER: out_imm={in_imm,8'h00}; go to OUT.
  - On transfer with PAIR: hi_byte<=in_imm; go to HOLD_HI.
- State HOLD_HI:
  - pair_pending=1, in_ready=1.
  - The next transfer is always the low byte; its in_mode is ignored.
  - On that transfer, out_imm={hi_byte,in_imm}; go to OUT.
- State OUT:
  - out_valid=1; out_imm is stable until the output transfer.
  - in_ready=out_ready, giving back-to-back throughput.
  - Output transfer with a simultaneous input transfer: process the new field exactly as IDLE would (stay in OUT or go to HOLD_HI).
  - Output transfer with no input transfer: go to IDLE with out_valid=0.
- Latency: one cycle from the final input transfer to out_valid=1. Throughput is one operand per cycle for single-beat modes and one per two cycles for PAIR.
- flush:
  - Has priority over every other event in the same cycle: go to IDLE, out_valid=0, pair_pending=0.
  - An input presented in the flush cycle is dropped; in_ready is forced to 0 during flush.
  - out_imm keeps its last value but is qualified invalid.
- Widths: all concatenations are exactly OUT_W. There is no arithmetic; the SEXT sign bit is in_imm[IN_W-1].
- Reset asserted mid-PAIR or mid-OUT: all state clears immediately (asynchronous) and the held byte is lost.
- Illegal or unreachable state encodings recover to IDLE.

Decomposition:
- Shared package: the mode encoding constants IMM_SEXT/IMM_ZEXT/IMM_UPPER/IMM_PAIR and the state encodings ST_IDLE/ST_HOLD_HI/ST_OUT, also used by the decoder.
- One combinational sub-module, imm_extend_core: takes mode, hi_byte and field, returns the OUT_W value.
- The FSM and output register stay in imm_seq_ctrl.

Test Plan:
- SEXT, ZEXT and UPPER: after reset, present 8'hF3 with each mode, out_ready=1.
  - Expect 16'hFFF3, 16'h00F3 and 16'hF300 respectively.
  - out_valid must rise one cycle after each transfer.
- PAIR: present 8'h12 (PAIR) then 8'h34 (mode=SEXT, ignored).
  - pair_pending=1 for one cycle, then out_imm=16'h1234.
  - The sign bit of 8'h34 must have no effect.
- Backpressure: hold out_ready=0 with out_valid=1 and in_valid=1.
  - in_ready=0 and out_imm stays constant.
  - When out_ready=1, exactly one new field is accepted in the same cycle.
- Streaming: in_valid and out_ready held high across 4 SEXT fields (8'h7F, 8'h80, 8'h00, 8'hFF).
  - Expect 16'h007F, 16'hFF80, 16'h0000, 16'hFFFF on consecutive cycles with no bubbles.
- Flush in HOLD_HI after 8'hAB (PAIR), with a valid input in the same cycle.
  - pair_pending drops, no output is produced, and the input is not accepted.
  - A following ZEXT 8'h01 yields 16'h0001.
- Reset mid-OUT: deassert rst_n asynchronously between clock edges.
  - out_valid=0 and out_imm=0 immediately.
  - After release, state is IDLE and in_ready=1.
